alu_share_arbiter: RTL and testbench

// - Shares the single combinational ALU between NREQ independent requesters (e.g. issue slots, address-gen unit).
// - Round-robin arbitration, valid/ready handshake on every request port and on the one response port.
// - Operands and command are registered before they drive the ALU; the result is registered before it is returned.
// - Sits between the decode/issue logic and the ALU instance; the ALU itself is instantiated outside this block.

---
 rtl/defines_pkg.sv | 17 +
 rtl/alu_share_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/defines_pkg.sv
// rtl/defines_pkg.sv - shared datapath width and ALU command encoding
package defines_pkg;

    parameter int N = 32;

    typedef enum logic [3:0] {
        EXE_ADD = 4'd0,
        EXE_SUB = 4'd1,
        EXE_AND = 4'd2,
        EXE_OR  = 4'd3,
        EXE_XOR = 4'd4,
        EXE_SLT = 4'd5,
        EXE_SLL = 4'd6,
        EXE_SRL = 4'd7
    } execmd_t;

endpackage

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU among NREQ requesters
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             per-requester handshake (req_ready one-hot or zero)
//   req_cmd/req_val1/req_val2       per-requester ALU command and operands
//   alu_cmd/alu_val1/alu_val2       registered operands driving the external ALU
//   alu_out/alu_zero                combinational ALU result
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/rsp_data/rsp_zero        registered requester index, result and zero flag
//   busy                            high while an operation is in flight (EXEC or RESP)
module alu_share_arbiter
    import defines_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  execmd_t                   req_cmd [NREQ],
    input  logic [NREQ-1:0][N-1:0]    req_val1,
    input  logic [NREQ-1:0][N-1:0]    req_val2,
    output execmd_t                   alu_cmd,
    output logic [N-1:0]              alu_val1,
    output logic [N-1:0]              alu_val2,
    input  logic [N-1:0]              alu_out,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [N-1:0]              rsp_data,
    output logic                      rsp_zero,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    execmd_t         cmd_q, cmd_d;
    logic [N-1:0]    val1_q, val1_d;
    logic [N-1:0]    val2_q, val2_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [N-1:0]    rsp_data_q, rsp_data_d;
    logic            rsp_zero_q, rsp_zero_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    int              cand;

    // Round-robin search: first valid index at or above rr_ptr, wrapping to 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!gnt_found && req_valid[IDW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(cand);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in IDLE a found grant is always accepted because
    // req_ready is raised for exactly the valid requester that was chosen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
        busy = (state_q != IDLE);
    end

    // Datapath next values; operand registers only load on accept so the
    // ALU inputs stay quiet between operations.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cmd_d       = cmd_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    cmd_d    = req_cmd[gnt_idx];
                    val1_d   = req_val1[gnt_idx];
                    val2_d   = req_val2[gnt_idx];
                    id_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : IDW'(gnt_idx + 1'b1);
                end
            end
            EXEC: begin
                rsp_data_d  = alu_out;
                rsp_zero_d  = alu_zero;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            cmd_q       <= EXE_ADD;
            val1_q      <= '0;
            val2_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cmd_q       <= cmd_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign alu_cmd   = cmd_q;
    assign alu_val1  = val1_q;
    assign alu_val2  = val2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import defines_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           req_valid;
    logic [3:0]           req_ready;
    execmd_t              req_cmd [4];
    logic [3:0][N-1:0]    req_val1;
    logic [3:0][N-1:0]    req_val2;
    execmd_t              alu_cmd;
    logic [N-1:0]         alu_val1;
    logic [N-1:0]         alu_val2;
    logic [N-1:0]         alu_out;
    logic                 alu_zero;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [N-1:0]         rsp_data;
    logic                 rsp_zero;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    alu_share_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_val1  (req_val1),
        .req_val2  (req_val2),
        .alu_cmd   (alu_cmd),
        .alu_val1  (alu_val1),
        .alu_val2  (alu_val2),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External ALU stand-in
    always_comb begin
        case (alu_cmd)
            EXE_ADD: alu_out = alu_val1 + alu_val2;
            EXE_SUB: alu_out = alu_val1 - alu_val2;
            EXE_AND: alu_out = alu_val1 & alu_val2;
            EXE_OR:  alu_out = alu_val1 | alu_val2;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input int p, input execmd_t c, input logic [N-1:0] a, input logic [N-1:0] b);
        req_cmd[p]  = c;
        req_val1[p] = a;
        req_val2[p] = b;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, EXE_ADD, '0, '0);
        #12;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %0h want 0", req_ready); end
        checks++; if (alu_cmd !== EXE_ADD) begin errors++; $display("FAIL reset_alu_cmd got %0h want %0h", alu_cmd, EXE_ADD); end
        checks++; if (alu_val1 !== '0 || alu_val2 !== '0) begin errors++; $display("FAIL reset_alu_vals got %0h/%0h want 0/0", alu_val1, alu_val2); end
        checks++; if (rsp_data !== '0 || rsp_id !== 2'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_fields got %0h/%0h/%0h want 0/0/0", rsp_data, rsp_id, rsp_zero); end
        #1 rst_n = 1'b1;
        step;
    endtask

    task automatic test_basic_add;
        set_op(0, EXE_ADD, 32'd5, 32'd7);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_grant got %0h want 1", req_ready); end
        step;
        req_valid = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL basic_exec got ready=%0h busy=%0h want ready=0 busy=1", req_ready, busy); end
        checks++; if (alu_val1 !== 32'd5 || alu_val2 !== 32'd7) begin errors++; $display("FAIL basic_alu_ops got %0h/%0h want 5/7", alu_val1, alu_val2); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_early_rsp got %0h want 0", rsp_valid); end
        step;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 2'd0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL basic_rsp got v=%0h d=%0h id=%0h z=%0h want v=1 d=c id=0 z=0", rsp_valid, rsp_data, rsp_id, rsp_zero);
        end
        step;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done got v=%0h busy=%0h want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin;
        int prev_cyc;
        int waited;
        int exp;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step;
        for (int i = 0; i < 4; i++) set_op(i, EXE_ADD, 32'(i * 10), 32'd1);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        prev_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            exp = k % 4;
            waited = 0;
            while (req_ready == 4'b0000 && waited < 6) begin
                step;
                waited++;
            end
            checks++; if (req_ready !== 4'(1 << exp)) begin errors++; $display("FAIL rr_grant_%0d got %0h want %0h", k, req_ready, 4'(1 << exp)); end
            if (k > 0) begin
                checks++; if (cyc - prev_cyc !== 3) begin errors++; $display("FAIL rr_spacing_%0d got %0d want 3", k, cyc - prev_cyc); end
            end
            prev_cyc = cyc;
            step;
            step;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp) || rsp_data !== 32'(exp * 10 + 1)) begin
                errors++; $display("FAIL rr_rsp_%0d got v=%0h id=%0h d=%0h want v=1 id=%0h d=%0h", k, rsp_valid, rsp_id, rsp_data, exp, exp * 10 + 1);
            end
            step;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_sub_zero;
        set_op(2, EXE_SUB, 32'd9, 32'd9);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sub_grant got %0h want 4", req_ready); end
        step;
        req_valid = 4'b0000;
        checks++; if (alu_cmd !== EXE_SUB) begin errors++; $display("FAIL sub_alu_cmd got %0h want %0h", alu_cmd, EXE_SUB); end
        step;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 2'd2) begin
            errors++; $display("FAIL sub_rsp got v=%0h d=%0h z=%0h id=%0h want v=1 d=0 z=1 id=2", rsp_valid, rsp_data, rsp_zero, rsp_id);
        end
        step;
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        set_op(0, EXE_ADD, 32'd3, 32'd4);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant got %0h want 1", req_ready); end
        step;
        req_valid = 4'b0000;
        step;
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd7 || rsp_id !== 2'd0 || rsp_zero !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d got v=%0h d=%0h id=%0h z=%0h want v=1 d=7 id=0 z=0", i, rsp_valid, rsp_data, rsp_id, rsp_zero);
            end
            checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d got ready=%0h busy=%0h want 0/1", i, req_ready, busy); end
            step;
        end
        rsp_ready = 1'b1;
        step;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %0h want 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant got %0h want 2", req_ready); end
        req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_wrap;
        set_op(3, EXE_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        set_op(0, EXE_OR, 32'h0000_00A0, 32'h0000_000B);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3 got %0h want 8", req_ready); end
        step;
        req_valid = 4'b0000;
        step;
        checks++; if (rsp_data !== 32'hF000_F000 || rsp_id !== 2'd3) begin errors++; $display("FAIL wrap_rsp3 got d=%0h id=%0h want d=f000f000 id=3", rsp_data, rsp_id); end
        step;
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant0 got %0h want 1", req_ready); end
        step;
        req_valid = 4'b0000;
        step;
        checks++; if (rsp_data !== 32'h0000_00AB || rsp_id !== 2'd0) begin errors++; $display("FAIL wrap_rsp0 got d=%0h id=%0h want d=ab id=0", rsp_data, rsp_id); end
        step;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) set_op(i, EXE_ADD, 32'((i + 1) * 100), 32'd5);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_grant got %0h want 2", req_ready); end
        step;
        step;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL rmid_resp got v=%0h id=%0h want 1/1", rsp_valid, rsp_id); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_async got v=%0h busy=%0h want 0/0", rsp_valid, busy); end
        checks++; if (rsp_data !== '0 || rsp_id !== 2'd0) begin errors++; $display("FAIL rmid_regs got d=%0h id=%0h want 0/0", rsp_data, rsp_id); end
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_regrant got %0h want 1", req_ready); end
        step;
        req_valid = 4'b0000;
        step;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'd105) begin
            errors++; $display("FAIL rmid_rsp got v=%0h id=%0h d=%0h want v=1 id=0 d=69", rsp_valid, rsp_id, rsp_data);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_basic_add;
        test_round_robin;
        test_sub_zero;
        test_backpressure;
        test_wrap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
